// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM destination shadows and produces bubble,
// stall and flush controls for the ID stage, plus a saturating bubble counter.
module hazard_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic        Use1_i,
  input  logic        Use2_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemRead_i,
  input  logic        Branch_i,
  input  logic        Taken_i,
  input  logic        MemStall_i,
  output logic        NoOp_o,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        Flush_o,
  output logic [15:0] StallCnt_o
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       regWrite;
    logic       memRead;
  } shadow_t;

  shadow_t     exReg, exNext;
  shadow_t     memReg, memNext;
  logic [15:0] stallCntReg, stallCntNext;

  logic [4:0]  srcAddr [2];
  logic        srcUse  [2];
  logic [1:0]  exMatch;
  logic [1:0]  memMatch;
  logic        loadUse;
  logic        branchHaz;
  logic        hazard;

  assign srcAddr[0] = RS1addr_i;
  assign srcAddr[1] = RS2addr_i;
  assign srcUse[0]  = Use1_i;
  assign srcUse[1]  = Use2_i;

  // A source only matches a live writer of a non-zero register it actually reads.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gSrc
      assign exMatch[gi]  = exReg.vld & exReg.regWrite & (exReg.rd != 5'd0) &
                            srcUse[gi] & (exReg.rd == srcAddr[gi]);
      assign memMatch[gi] = memReg.vld & memReg.regWrite & (memReg.rd != 5'd0) &
                            srcUse[gi] & (memReg.rd == srcAddr[gi]);
    end
  endgenerate

  assign loadUse   = (|exMatch) & exReg.memRead;
  assign branchHaz = Branch_i & ((|exMatch) | ((|memMatch) & memReg.memRead));
  assign hazard    = (loadUse | branchHaz) & valid_i;

  always_comb begin
    NoOp_o      = 1'b0;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    Flush_o     = 1'b0;
    if (!rst_i) begin
      if (MemStall_i) begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
      end else if (hazard) begin
        NoOp_o      = 1'b1;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
      end else begin
        Flush_o = valid_i & Branch_i & Taken_i;
      end
    end
  end

  // A bubble enters EX as an invalid entry, so it can never match later.
  always_comb begin
    exNext  = exReg;
    memNext = memReg;
    if (!MemStall_i) begin
      memNext          = exReg;
      exNext.vld       = valid_i & ~NoOp_o;
      exNext.rd        = RDaddr_i;
      exNext.regWrite  = RegWrite_i;
      exNext.memRead   = MemRead_i;
    end
  end

  always_comb begin
    stallCntNext = stallCntReg;
    if (NoOp_o && (stallCntReg != 16'hFFFF)) begin
      stallCntNext = stallCntReg + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exReg.vld   <= 1'b0;
      memReg.vld  <= 1'b0;
      stallCntReg <= 16'd0;
    end else begin
      exReg       <= exNext;
      memReg      <= memNext;
      stallCntReg <= stallCntNext;
    end
  end

  assign StallCnt_o = stallCntReg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed, table-driven check of hazard_unit: each record is one cycle of ID
// inputs with the hand-derived control outputs and bubble count for that cycle.
module tb_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic        Use1_i, Use2_i;
  logic        RegWrite_i, MemRead_i, Branch_i, Taken_i, MemStall_i;
  logic        NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o;
  logic [15:0] StallCnt_o;

  int checkCount = 0;
  int failCount  = 0;

  hazard_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .RS1addr_i   (RS1addr_i),
    .RS2addr_i   (RS2addr_i),
    .Use1_i      (Use1_i),
    .Use2_i      (Use2_i),
    .RDaddr_i    (RDaddr_i),
    .RegWrite_i  (RegWrite_i),
    .MemRead_i   (MemRead_i),
    .Branch_i    (Branch_i),
    .Taken_i     (Taken_i),
    .MemStall_i  (MemStall_i),
    .NoOp_o      (NoOp_o),
    .PCWrite_o   (PCWrite_o),
    .IFIDWrite_o (IFIDWrite_o),
    .Flush_o     (Flush_o),
    .StallCnt_o  (StallCnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, ms, valid;
    logic [4:0]  rs1;
    logic        use1;
    logic [4:0]  rs2;
    logic        use2;
    logic [4:0]  rd;
    logic        rw, mr, br, tk;
    logic [3:0]  expCtl;   // {NoOp, PCWrite, IFIDWrite, Flush}
    logic [15:0] expCnt;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic ms, input logic valid,
                             input logic [4:0] rs1, input logic use1,
                             input logic [4:0] rs2, input logic use2,
                             input logic [4:0] rd, input logic rw, input logic mr,
                             input logic br, input logic tk,
                             input logic [3:0] expCtl, input logic [15:0] expCnt);
    vec_t r;
    r.rst = rst; r.ms = ms; r.valid = valid;
    r.rs1 = rs1; r.use1 = use1; r.rs2 = rs2; r.use2 = use2;
    r.rd = rd; r.rw = rw; r.mr = mr; r.br = br; r.tk = tk;
    r.expCtl = expCtl; r.expCnt = expCnt;
    return r;
  endfunction

  task automatic runVec(input vec_t x, input string tag);
    logic [3:0] ctl;
    @(negedge clk_i);
    rst_i = x.rst; MemStall_i = x.ms; valid_i = x.valid;
    RS1addr_i = x.rs1; Use1_i = x.use1; RS2addr_i = x.rs2; Use2_i = x.use2;
    RDaddr_i = x.rd; RegWrite_i = x.rw; MemRead_i = x.mr;
    Branch_i = x.br; Taken_i = x.tk;
    #1;
    ctl = {NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o};
    checkCount++;
    if (ctl !== x.expCtl) begin
      failCount++;
      $display("FAIL %s ctl: got %b expected %b", tag, ctl, x.expCtl);
    end
    checkCount++;
    if (StallCnt_o !== x.expCnt) begin
      failCount++;
      $display("FAIL %s cnt: got %h expected %h", tag, StallCnt_o, x.expCnt);
    end
    $display("%s: ctl=%b cnt=%h", tag, ctl, StallCnt_o);
  endtask

  vec_t vecs [26];

  initial begin
    rst_i = 1'b1; MemStall_i = 1'b0; valid_i = 1'b0;
    RS1addr_i = '0; RS2addr_i = '0; RDaddr_i = '0;
    Use1_i = 1'b0; Use2_i = 1'b0; RegWrite_i = 1'b0; MemRead_i = 1'b0;
    Branch_i = 1'b0; Taken_i = 1'b0;

    // reset, load-use, branch-after-load, branch-after-ALU, x0 / unused source
    vecs[0]  = v(1,0,1,  0,0, 0,0,  0,0,0,1,1, 4'b0110, 16'd0);
    vecs[1]  = v(1,0,0,  0,0, 0,0,  0,0,0,0,0, 4'b0110, 16'd0);
    vecs[2]  = v(0,0,1,  0,0, 0,0,  5,1,1,0,0, 4'b0110, 16'd0);
    vecs[3]  = v(0,0,1,  5,1, 1,1,  6,1,0,0,0, 4'b1000, 16'd0);
    vecs[4]  = v(0,0,1,  5,1, 1,1,  6,1,0,0,0, 4'b0110, 16'd1);
    vecs[5]  = v(0,0,1,  0,0, 0,0,  7,1,1,0,0, 4'b0110, 16'd1);
    vecs[6]  = v(0,0,1,  7,1, 0,1,  0,0,0,1,1, 4'b1000, 16'd1);
    vecs[7]  = v(0,0,1,  7,1, 0,1,  0,0,0,1,1, 4'b1000, 16'd2);
    vecs[8]  = v(0,0,1,  7,1, 0,1,  0,0,0,1,1, 4'b0111, 16'd3);
    vecs[9]  = v(0,0,1,  0,0, 0,0,  3,1,0,0,0, 4'b0110, 16'd3);
    vecs[10] = v(0,0,1,  3,1, 4,1,  0,0,0,1,0, 4'b1000, 16'd3);
    vecs[11] = v(0,0,1,  3,1, 4,1,  0,0,0,1,0, 4'b0110, 16'd4);
    vecs[12] = v(0,0,1,  1,1, 2,1,  0,0,0,1,1, 4'b0111, 16'd4);
    vecs[13] = v(0,0,1,  0,0, 0,0,  0,1,1,0,0, 4'b0110, 16'd4);
    vecs[14] = v(0,0,1,  0,1, 0,1,  1,1,0,0,0, 4'b0110, 16'd4);
    vecs[15] = v(0,0,1,  0,0, 0,0,  5,1,1,0,0, 4'b0110, 16'd4);
    vecs[16] = v(0,0,1,  9,1, 5,0,  8,1,0,0,0, 4'b0110, 16'd4);
    vecs[17] = v(0,0,1,  0,0, 0,0,  5,1,1,0,0, 4'b0110, 16'd4);
    vecs[18] = v(0,0,0,  5,1, 0,0,  0,0,0,1,1, 4'b0110, 16'd4);
    vecs[19] = v(0,0,1,  5,1, 0,0,  0,0,0,1,1, 4'b1000, 16'd4);
    vecs[20] = v(0,0,1,  5,1, 0,0,  0,0,0,1,1, 4'b0111, 16'd5);
    vecs[21] = v(0,0,1,  0,0, 0,0, 12,1,1,0,0, 4'b0110, 16'd5);
    vecs[22] = v(0,0,1,  4,1,12,1, 13,1,0,0,0, 4'b1000, 16'd5);
    vecs[23] = v(0,0,1,  4,1,12,1, 13,1,0,0,0, 4'b0110, 16'd6);
    vecs[24] = v(0,0,0,  0,0, 0,0, 14,1,1,0,0, 4'b0110, 16'd6);
    vecs[25] = v(0,0,1, 14,1, 0,0, 15,1,0,0,0, 4'b0110, 16'd6);

    for (int i = 0; i < 26; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // memory stall freezes a pending load-use bubble, then exactly one bubble
    runVec(v(0,0,1, 0,0, 0,0, 5,1,1,0,0, 4'b0110, 16'd6), "ms_lw");
    for (int i = 0; i < 3; i++) begin
      runVec(v(0,1,1, 5,1, 1,1, 6,1,0,0,0, 4'b0000, 16'd6), $sformatf("ms_hold%0d", i));
    end
    runVec(v(0,0,1, 5,1, 1,1, 6,1,0,0,0, 4'b1000, 16'd6), "ms_bubble");
    runVec(v(0,0,1, 5,1, 1,1, 6,1,0,0,0, 4'b0110, 16'd7), "ms_go");

    // reset (with memory stall also high) on the first bubble of a load->branch stall
    runVec(v(0,0,1, 0,0, 0,0, 7,1,1,0,0, 4'b0110, 16'd7), "rst_lw");
    runVec(v(1,1,1, 7,1, 0,1, 0,0,0,1,1, 4'b0110, 16'd7), "rst_bubble");
    runVec(v(0,0,1, 7,1, 0,1, 0,0,0,1,1, 4'b0111, 16'd0), "rst_after");

    // preload the counter near its limit and drive it into saturation
    force dut.stallCntReg = 16'hFFFD;
    #1;
    release dut.stallCntReg;
    runVec(v(0,0,1, 0,0, 0,0, 5,1,1,0,0, 4'b0110, 16'hFFFD), "sat_lw0");
    runVec(v(0,0,1, 5,1, 1,1, 6,1,0,0,0, 4'b1000, 16'hFFFD), "sat_b0");
    runVec(v(0,0,1, 5,1, 1,1, 6,1,0,0,0, 4'b0110, 16'hFFFE), "sat_go0");
    runVec(v(0,0,1, 0,0, 0,0, 5,1,1,0,0, 4'b0110, 16'hFFFE), "sat_lw1");
    runVec(v(0,0,1, 5,1, 1,1, 6,1,0,0,0, 4'b1000, 16'hFFFE), "sat_b1");
    runVec(v(0,0,1, 5,1, 1,1, 6,1,0,0,0, 4'b0110, 16'hFFFF), "sat_go1");
    runVec(v(0,0,1, 0,0, 0,0, 5,1,1,0,0, 4'b0110, 16'hFFFF), "sat_lw2");
    runVec(v(0,0,1, 5,1, 1,1, 6,1,0,0,0, 4'b1000, 16'hFFFF), "sat_b2");
    runVec(v(0,0,1, 5,1, 1,1, 6,1,0,0,0, 4'b0110, 16'hFFFF), "sat_go2");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
